fifo_rd_cntrl: RTL and testbench
================================

// Module: fifo_rd_cntrl
// PURPOSE
//  Read-side controller of the async FIFO; sits downstream of the FIFO memory in the read clock domain.
//  - Owns the read pointer (binary and Gray) and the empty flag.
//  - Drives the memory read address.
//  - Registers the memory's combinational read data into a first-word-fall-through output stage
//    with a valid/ready handshake toward the consumer (e.g. UART TX).
// PARAMETERS
//  DATA_WIDTH      8  word width; matches the FIFO memory
//  ADDR_WIDTH      5  memory address width; depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
//  ALMOST_EMPTY_TH 2  level at or below which o_almost_empty asserts (FIFO_RD_LEVEL_EN only)
// PORTS
//  i_r_clk        in   1             read-domain clock; the only clock in this block
//  i_r_rst        in   1             synchronous, active-high reset
//  i_wptr_gray    in   ADDR_WIDTH+1  write pointer (Gray), already synchronized into i_r_clk
//  i_rd_data      in   DATA_WIDTH    memory read data for o_rd_addr (combinational)
//  i_ready        in   1             consumer accepts o_data this cycle
//  o_rd_addr      out  ADDR_WIDTH    memory read address = rptr_bin[ADDR_WIDTH-1:0]
//  o_rptr_gray    out  ADDR_WIDTH+1  registered Gray read pointer, to the write-domain synchronizer
//  o_empty        out  1             memory holds no unread word (registered)
//  o_data         out  DATA_WIDTH    output word
//  o_valid        out  1             o_data holds a valid word
//  o_level        out  ADDR_WIDTH+1  words in memory (FIFO_RD_LEVEL_EN only)
//  o_almost_empty out  1             o_level <= ALMOST_EMPTY_TH (FIFO_RD_LEVEL_EN only)
// BEHAVIOUR
//  Reset: rptr_bin=0, o_rptr_gray=0, o_empty=1, o_valid=0, o_data=0, o_level=0, o_almost_empty=1.
//  Reset mid-operation discards both the unread memory words and the output-register word.
//  Handshake and pointer advance:
//  - load    = ~o_empty & (~o_valid | i_ready)
//  - rd_inc  = load
//  - rbin_nx = rptr_bin + rd_inc, modulo 2**(ADDR_WIDTH+1); natural wrap, no saturation
//  - rgray_nx = rbin_nx ^ (rbin_nx >> 1)
//  Registered each edge:
//  - rptr_bin    <= rbin_nx
//  - o_rptr_gray <= rgray_nx
//  - o_empty     <= (rgray_nx == i_wptr_gray)
//  Output stage:
//  - load                       -> o_data <= i_rd_data, o_valid <= 1
//  - ~load & o_valid & i_ready  -> o_valid <= 0; o_data holds its last value
//  - o_valid & ~i_ready         -> o_data and o_valid hold (no change)
//  Latency:
//  - i_wptr_gray change seen at edge k -> o_empty falls after edge k -> o_valid rises after edge k+1.
//  Throughput:
//  - o_valid & i_ready & ~o_empty on the same edge -> next word loaded, o_valid stays 1.
//  - Sustains one word per cycle.
//  Boundary conditions:
//  - Empty: no load and no pointer movement; o_rd_addr is stable.
//  - Last word: empty reasserts on the same edge the last word is loaded.
//  - Wrap-around: pointer MSB toggles every 2**ADDR_WIDTH reads; o_rd_addr wraps to 0.
//  - Equality is compared on the full Gray pointer, MSB included.
//  - Stale synchronized write pointer: the block may report empty pessimistically; it never reads past written data.
// CONFIGURATION
//  FIFO_RD_LEVEL_EN defined:
//  - wbin_q <= gray2bin(i_wptr_gray)
//  - o_level <= wbin_q - rptr_bin, modulo 2**(ADDR_WIDTH+1); the word in the output register is not counted
//  - o_almost_empty <= (wbin_q - rptr_bin) <= ALMOST_EMPTY_TH
//  - o_level lags by one extra cycle relative to o_empty.
//  FIFO_RD_LEVEL_EN undefined:
//  - o_level and o_almost_empty are tied to 0; no gray2bin logic or level registers are built.
//  - All other behaviour is identical.
// STRUCTURE
//  Shared package fifo_pkg:
//  - PTR_WIDTH(ADDR_WIDTH) constant function
//  - bin2gray and gray2bin functions; also used by the write-side controller
//  Sub-module fifo_rd_out_stage:
//  - FWFT data register + valid/ready logic
//  - Inputs: load, i_rd_data, i_ready
//  - Outputs: o_data, o_valid
//  - The parent owns the pointers, empty flag and level logic.
// TESTING
//  1. Reset with i_wptr_gray=0 -> o_empty=1, o_valid=0, o_rd_addr=0, o_rptr_gray=0; hold for 5 cycles, no change.
//  2. i_wptr_gray 0->1 (mem[0]=0xA5), i_ready=0:
//     - o_empty=0 after 1 edge; o_valid=1, o_data=0xA5 after 2 edges; o_rptr_gray=1; o_empty=1.
//  3. Write 4 words (0x11..0x44), i_ready=1 throughout -> 0x11,0x22,0x33,0x44 on 4 consecutive cycles, then o_valid=0.
//  4. Backpressure: 3 words, i_ready=0 for 6 cycles -> o_data=first word stable; o_rd_addr advanced by 1 only.
//  5. Wrap, ADDR_WIDTH=5: stream 70 words -> o_rd_addr rolls 31->0; o_rptr_gray MSB toggles after read 32;
//     every word matches, with no loss or duplication.
//  6. FIFO_RD_LEVEL_EN, wptr at 5 words, no reads -> o_level=5, o_almost_empty=0;
//     drain to 2 -> o_almost_empty=1. Reset asserted mid-stream -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width and Gray/binary conversion, used by both
// the read-side and the write-side controllers.
package fifo_pkg;

    localparam int unsigned MAX_PTR_W = 32;

    function automatic int unsigned PTR_WIDTH(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int unsigned i = 1; i < MAX_PTR_W; i++) begin
            b[MAX_PTR_W-1-i] = b[MAX_PTR_W-i] ^ g[MAX_PTR_W-1-i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_out_stage.sv
// First-word-fall-through output register with a valid/ready handshake toward the consumer.
module fifo_rd_out_stage #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (i_load) begin
            data_d  = i_rd_data;
            valid_d = 1'b1;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: rtl/fifo_rd_cntrl.sv
// Async FIFO read-side controller: read pointer (binary/Gray), empty flag, FWFT output.
// Optional occupancy outputs are built only when FIFO_RD_LEVEL_EN is defined.
module fifo_rd_cntrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH      = 5,
    parameter int unsigned ALMOST_EMPTY_TH = 2
) (
    input  logic                  i_r_clk,
    input  logic                  i_r_rst,
    input  logic [ADDR_WIDTH:0]   i_wptr_gray,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    input  logic                  i_ready,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic [ADDR_WIDTH:0]   o_rptr_gray,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_almost_empty
);

    localparam int unsigned PW = PTR_WIDTH(ADDR_WIDTH);

    if (ALMOST_EMPTY_TH >= (64'd1 << PW)) begin : g_bad_th
        $error("ALMOST_EMPTY_TH exceeds the pointer range");
    end

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rgray_q, rgray_d;
    logic          empty_q, empty_d;
    logic          load;

    assign load = ~empty_q & (~o_valid | i_ready);

    always_comb begin
        rbin_d  = rbin_q + PW'(load);
        rgray_d = PW'(bin2gray(MAX_PTR_W'(rbin_d)));
        empty_d = (rgray_d == i_wptr_gray);
    end

    always_ff @(posedge i_r_clk) begin
        if (i_r_rst) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            empty_q <= 1'b1;
        end else begin
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            empty_q <= empty_d;
        end
    end

    assign o_rd_addr   = rbin_q[ADDR_WIDTH-1:0];
    assign o_rptr_gray = rgray_q;
    assign o_empty     = empty_q;

    fifo_rd_out_stage #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_stage (
        .i_clk    (i_r_clk),
        .i_rst    (i_r_rst),
        .i_load   (load),
        .i_rd_data(i_rd_data),
        .i_ready  (i_ready),
        .o_data   (o_data),
        .o_valid  (o_valid)
    );

`ifdef FIFO_RD_LEVEL_EN
    logic [PW-1:0] wbin_q;
    logic [PW-1:0] level_q, level_d;
    logic          aempty_q;

    assign level_d = wbin_q - rbin_q;

    // Level uses the previously registered write pointer, so it trails o_empty by a cycle.
    always_ff @(posedge i_r_clk) begin
        if (i_r_rst) begin
            wbin_q   <= '0;
            level_q  <= '0;
            aempty_q <= 1'b1;
        end else begin
            wbin_q   <= PW'(gray2bin(MAX_PTR_W'(i_wptr_gray)));
            level_q  <= level_d;
            aempty_q <= (level_d <= PW'(ALMOST_EMPTY_TH));
        end
    end

    assign o_level        = level_q;
    assign o_almost_empty = aempty_q;
`else
    assign o_level        = '0;
    assign o_almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_cntrl.sv
// Directed self-checking bench for fifo_rd_cntrl; models the FIFO memory and write pointer.
module tb_fifo_rd_cntrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW:0]   wptr_gray;
    logic [DW-1:0] rd_data;
    logic          ready;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   rptr_gray;
    logic          empty;
    logic [DW-1:0] data;
    logic          valid;
    logic [AW:0]   level;
    logic          aempty;

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wbin;
    int            total = 0;
    int            bad   = 0;

`ifdef FIFO_RD_LEVEL_EN
    localparam logic AE_RST = 1'b1;
`else
    localparam logic AE_RST = 1'b0;
`endif

    always #5 clk = ~clk;

    assign rd_data   = mem[rd_addr];
    assign wptr_gray = wbin ^ (wbin >> 1);

    fifo_rd_cntrl #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .ALMOST_EMPTY_TH(2)
    ) dut (
        .i_r_clk       (clk),
        .i_r_rst       (rst),
        .i_wptr_gray   (wptr_gray),
        .i_rd_data     (rd_data),
        .i_ready       (ready),
        .o_rd_addr     (rd_addr),
        .o_rptr_gray   (rptr_gray),
        .o_empty       (empty),
        .o_data        (data),
        .o_valid       (valid),
        .o_level       (level),
        .o_almost_empty(aempty)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wbin[AW-1:0]] = w;
        wbin = wbin + 1'b1;
    endtask

    initial begin
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] w;
        int            got_n;
        int            sent;
        logic          wrap_seen;
        logic          msb_seen;
        logic [AW-1:0] prev_addr;

        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
        rst = 1'b1; ready = 1'b0; wbin = '0;
        tick(); tick();
        rst = 1'b0;

        // 1: reset state and idle hold
        check("rst_empty", 32'(empty), 1);
        check("rst_valid", 32'(valid), 0);
        check("rst_data", 32'(data), 0);
        check("rst_addr", 32'(rd_addr), 0);
        check("rst_gray", 32'(rptr_gray), 0);
        check("rst_level", 32'(level), 0);
        check("rst_aempty", 32'(aempty), 32'(AE_RST));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_empty", 32'(empty), 1);
            check("idle_valid", 32'(valid), 0);
            check("idle_addr", 32'(rd_addr), 0);
        end

        // 2: single word, consumer not ready
        push(8'hA5);
        tick();
        check("t2_empty0", 32'(empty), 0);
        check("t2_valid0", 32'(valid), 0);
        tick();
        check("t2_valid", 32'(valid), 1);
        check("t2_data", 32'(data), 32'hA5);
        check("t2_gray", 32'(rptr_gray), 1);
        check("t2_empty1", 32'(empty), 1);
        check("t2_addr", 32'(rd_addr), 1);
        tick();
        check("t2_hold", 32'(valid), 1);
        ready = 1'b1;
        tick();
        check("t2_drop_valid", 32'(valid), 0);
        check("t2_keep_data", 32'(data), 32'hA5);

        // 3: four words back-to-back with ready high
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        tick();
        check("t3_empty0", 32'(empty), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_valid", 32'(valid), 1);
            check("t3_data", 32'(data), 32'(8'h11 * (i + 1)));
        end
        check("t3_empty_last", 32'(empty), 1);
        tick();
        check("t3_valid_end", 32'(valid), 0);
        check("t3_addr", 32'(rd_addr), 5);

        // 4: backpressure
        ready = 1'b0;
        push(8'hA1); push(8'hA2); push(8'hA3);
        tick(); tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_valid", 32'(valid), 1);
            check("t4_data", 32'(data), 32'hA1);
            check("t4_addr", 32'(rd_addr), 6);
        end
        ready = 1'b1;
        tick();
        check("t4_d2", 32'(data), 32'hA2);
        tick();
        check("t4_d3", 32'(data), 32'hA3);
        check("t4_empty", 32'(empty), 1);
        tick();
        check("t4_valid_end", 32'(valid), 0);

        // 5: stream 70 words through the pointer wrap
        got_n = 0; sent = 0; wrap_seen = 1'b0; msb_seen = 1'b0;
        prev_addr = rd_addr;
        for (int cyc = 0; cyc < 300 && got_n < 70; cyc++) begin
            if (sent < 70) begin
                w = 8'(8'h40 + sent * 7);
                push(w);
                exp_q.push_back(w);
                sent++;
            end
            tick();
            if (prev_addr == 5'd31 && rd_addr == 5'd0) wrap_seen = 1'b1;
            if (rptr_gray[AW]) msb_seen = 1'b1;
            prev_addr = rd_addr;
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("t5_extra_word", 32'(data), 32'hFFFF_FFFF);
                end else begin
                    check("t5_word", 32'(data), 32'(exp_q.pop_front()));
                end
                got_n++;
            end
        end
        check("t5_count", 32'(got_n), 70);
        tick();
        check("t5_valid_end", 32'(valid), 0);
        check("t5_empty", 32'(empty), 1);
        check("t5_addr", 32'(rd_addr), 14);
        check("t5_gray", 32'(rptr_gray), 32'h09);
        check("t5_wrap", 32'(wrap_seen), 1);
        check("t5_msb", 32'(msb_seen), 1);

        // 6: level / almost-empty, then reset mid-stream
        ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        tick();
        check("t6_empty0", 32'(empty), 0);
        tick();
        check("t6_data", 32'(data), 32'hC0);
`ifdef FIFO_RD_LEVEL_EN
        check("t6_level5", 32'(level), 5);
        check("t6_ae0", 32'(aempty), 0);
        tick();
        check("t6_level4", 32'(level), 4);
        ready = 1'b1;
        tick(); tick(); tick();
        check("t6_level2", 32'(level), 2);
        check("t6_ae1", 32'(aempty), 1);
`else
        check("t6_level_tied", 32'(level), 0);
        check("t6_ae_tied", 32'(aempty), 0);
        ready = 1'b1;
        tick();
        check("t6_data2", 32'(data), 32'hC1);
`endif
        check("t6_valid_pre", 32'(valid), 1);
        rst = 1'b1;
        wbin = '0;
        tick();
        check("t6_rst_empty", 32'(empty), 1);
        check("t6_rst_valid", 32'(valid), 0);
        check("t6_rst_data", 32'(data), 0);
        check("t6_rst_addr", 32'(rd_addr), 0);
        check("t6_rst_gray", 32'(rptr_gray), 0);
        check("t6_rst_level", 32'(level), 0);
        check("t6_rst_aempty", 32'(aempty), 32'(AE_RST));
        rst = 1'b0;
        tick(); tick();
        check("t6_post_empty", 32'(empty), 1);
        check("t6_post_valid", 32'(valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
